inst_fetch: RTL and testbench

Instruction fetch stage of the AKARIN RV32I pipeline, directly upstream of the decode stage. It accepts the word PC that decode computes each cycle and issues in-order requests to instruction memory. Returned words are held in a small in-order fetch buffer and presented to decode as `if2decPkt`. When the buffer cannot take a new request, it raises a busy flag to the hazard logic; a flush input discards all buffered and in-flight fetches.

---
 rtl/inst_fetch_pkg.sv | 29 ++
 rtl/fetch_buf.sv | 86 ++++++++
 rtl/inst_fetch.sv | 112 +++++++++++
 tb/tb_inst_fetch.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage types and constants for the AKARIN RV32I pipeline.
// Latency: n/a (types only).
// Backpressure: n/a.
package inst_fetch_pkg;

  localparam int          FETCH_DEPTH = 4;
  localparam logic [31:0] INST_NOP    = 32'h0000_0013;  // addi x0, x0, 0

  // One fetch-buffer slot: word PC, returned instruction, response-arrived flag.
  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] inst32;
    logic        filled;
  } fetchEntry_t;

  // Decode -> fetch: next word PC to fetch.
  typedef struct packed {
    logic [29:0] pc;
    logic        pcValid;
  } dec2ifPkt;

  // Fetch -> decode: instruction presented this cycle.
  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] inst32;
    logic        instValid;
  } if2decPkt;

endpackage

// File: rtl/fetch_buf.sv
// In-order fetch ring: alloc on request, fill on response, pop to decode.
// Latency: writes visible the cycle after the strobe; head/occ/inflight are registered.
// Backpressure: none internally; the owner must only alloc while occ < DEPTH (macro AKARIN_FETCH_BYPASS_EN adds fill_at_head_o).
module fetch_buf
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  localparam int PW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_i,
  input  logic [29:0]   alloc_pc_i,
  input  logic          fill_i,
  input  logic [31:0]   fill_inst_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output fetchEntry_t   head_o,
  output logic [PW-1:0] occ_o,
  output logic [PW-1:0] inflight_o
`ifdef AKARIN_FETCH_BYPASS_EN
  ,
  output logic          fill_at_head_o
`endif
);

  localparam int IW = PW - 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] fill_q, fill_d;
  logic [PW-1:0] head_q, head_d;
  fetchEntry_t   ent_q [DEPTH];

  // Pointer advance; a flush collapses head and fill onto tail.
  always_comb begin
    tail_d = tail_q;
    fill_d = fill_q;
    head_d = head_q;
    if (flush_i) begin
      fill_d = tail_q;
      head_d = tail_q;
    end else begin
      if (alloc_i) tail_d = tail_q + PW'(1);
      if (fill_i)  fill_d = fill_q + PW'(1);
      if (pop_i)   head_d = head_q + PW'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tail_q <= '0;
      fill_q <= '0;
      head_q <= '0;
    end else begin
      tail_q <= tail_d;
      fill_q <= fill_d;
      head_q <= head_d;
    end
  end

  // Slot storage: alloc records the PC and clears filled, fill stores the word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      if (alloc_i && !flush_i) begin
        ent_q[tail_q[IW-1:0]].pc     <= alloc_pc_i;
        ent_q[tail_q[IW-1:0]].filled <= 1'b0;
      end
      if (fill_i && !flush_i) begin
        ent_q[fill_q[IW-1:0]].inst32 <= fill_inst_i;
        ent_q[fill_q[IW-1:0]].filled <= 1'b1;
      end
    end
  end

  assign head_o     = ent_q[head_q[IW-1:0]];
  assign occ_o      = tail_q - head_q;
  assign inflight_o = tail_q - fill_q;
`ifdef AKARIN_FETCH_BYPASS_EN
  assign fill_at_head_o = (fill_q == head_q);
`endif

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: issues in-order imem requests for decode's PC and presents returned words to decode.
// Latency: accept at T, response at T+k -> instValid at T+k+1 (T+k with AKARIN_FETCH_BYPASS_EN defined).
// Backpressure: fetchBusy_o when the buffer is full, imem not ready, or flushing; stall holds the head entry.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH  // power of 2, >= 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush_i,
  input  dec2ifPkt    dec2if_i,
  output logic        fetchBusy_o,
  output if2decPkt    if2dec_o,
  output logic        imemReq_o,
  output logic [29:0] imemAddr_o,
  input  logic        imemRdy_i,
  input  logic        imemRvalid_i,
  input  logic [31:0] imemRdata_i
);

  localparam int PW    = $clog2(DEPTH) + 1;
  // Room for several flushes' worth of abandoned requests still in memory.
  localparam int CNT_W = PW + 3;

  fetchEntry_t      head;
  logic [PW-1:0]    occ;
  logic [PW-1:0]    inflight;
  logic [CNT_W-1:0] dropCnt_q, dropCnt_d;
  logic             canIssue;
  logic             accept;
  logic             orphan;
  logic             respUsed;
  logic             fillEn;
  logic             pop;
`ifdef AKARIN_FETCH_BYPASS_EN
  logic             fillAtHead;
`endif

  // Issue gating uses registered occupancy only, never pcValid, to keep stall loop-free.
  assign canIssue    = (occ < PW'(DEPTH)) && imemRdy_i && !flush_i;
  assign accept      = dec2if_i.pcValid && canIssue;
  assign fetchBusy_o = !canIssue;
  assign imemReq_o   = accept;
  assign imemAddr_o  = dec2if_i.pc;

  // A response is orphaned when nothing is outstanding, live or abandoned.
  assign orphan   = (dropCnt_q == '0) && (inflight == '0);
  assign respUsed = imemRvalid_i && !orphan;
  assign fillEn   = respUsed && (dropCnt_q == '0) && !flush_i;

  // Decode view: head entry when filled, optional same-cycle bypass, else NOP bubble.
  always_comb begin
    if2dec_o.pc        = head.pc;
    if2dec_o.inst32    = INST_NOP;
    if2dec_o.instValid = 1'b0;
    if (!flush_i && (occ != '0)) begin
      if (head.filled) begin
        if2dec_o.inst32    = head.inst32;
        if2dec_o.instValid = 1'b1;
      end
`ifdef AKARIN_FETCH_BYPASS_EN
      else if (fillAtHead && imemRvalid_i && (dropCnt_q == '0)) begin
        if2dec_o.inst32    = imemRdata_i;
        if2dec_o.instValid = 1'b1;
      end
`endif
    end
  end

  assign pop = if2dec_o.instValid && !stall;

  // Drop counter: a flush adds every live in-flight request to those already abandoned;
  // a response arriving in the flush cycle retires one of them immediately.
  always_comb begin
    dropCnt_d = dropCnt_q;
    if (flush_i) begin
      dropCnt_d = dropCnt_q + CNT_W'(inflight) - CNT_W'(respUsed);
    end else if (imemRvalid_i && (dropCnt_q != '0)) begin
      dropCnt_d = dropCnt_q - CNT_W'(1);
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dropCnt_q <= '0;
    else      dropCnt_q <= dropCnt_d;
  end

  fetch_buf #(.DEPTH(DEPTH)) u_buf (
    .clk         (clk),
    .rst         (rst),
    .alloc_i     (accept),
    .alloc_pc_i  (dec2if_i.pc),
    .fill_i      (fillEn),
    .fill_inst_i (imemRdata_i),
    .pop_i       (pop),
    .flush_i     (flush_i),
    .head_o      (head),
    .occ_o       (occ),
    .inflight_o  (inflight)
`ifdef AKARIN_FETCH_BYPASS_EN
    ,
    .fill_at_head_o(fillAtHead)
`endif
  );

  // Memory must never answer a request that was not made.
  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst) imemRvalid_i |-> !orphan);

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  dec2ifPkt    dec2if = '0;
  logic        fetchBusy;
  if2decPkt    if2dec;
  logic        imemReq;
  logic [29:0] imemAddr;
  logic        imemRdy = 1'b0;
  logic        imemRvalid = 1'b0;
  logic [31:0] imemRdata = '0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [29:0] pc;
    int          due;
  } mreq_t;

  logic [29:0] expQ[$];   // accepted, not yet delivered, not flushed
  mreq_t       memQ[$];   // requests the memory still owes a response for
  int          edgeCnt = 0;
  int          latLo = 0;
  int          latHi = 0;

  always #5 clk = ~clk;

  inst_fetch #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush_i      (flush),
    .dec2if_i     (dec2if),
    .fetchBusy_o  (fetchBusy),
    .if2dec_o     (if2dec),
    .imemReq_o    (imemReq),
    .imemAddr_o   (imemAddr),
    .imemRdy_i    (imemRdy),
    .imemRvalid_i (imemRvalid),
    .imemRdata_i  (imemRdata)
  );

  function automatic logic [31:0] memWord(logic [29:0] pc);
    return {pc, 2'b11} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    dec2if.pcValid = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    imemRdy = 1'b1;
    repeat (n) step();
  endtask

  // Instruction memory: in-order, at least one cycle after acceptance, shares reset.
  initial begin
    forever begin
      @(posedge clk);
      edgeCnt++;
      #1;
      imemRvalid = 1'b0;
      if (!rst) begin
        memQ.delete();
      end else if (memQ.size() != 0 && memQ[0].due <= edgeCnt) begin
        imemRvalid = 1'b1;
        imemRdata  = memWord(memQ[0].pc);
        void'(memQ.pop_front());
      end
    end
  end

  // Scoreboard monitor: reference is "accepted PCs come back in order, a flush forgets them all".
  initial begin
    logic        busyExp;
    logic [29:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        expQ.delete();
        memQ.delete();
      end else begin
        busyExp = !((expQ.size() < DEPTH) && imemRdy && !flush);
        check("busy", fetchBusy, busyExp);
        check("req", imemReq, dec2if.pcValid && !busyExp);
        if (flush) check("flush_valid", if2dec.instValid, 1'b0);
        if (if2dec.instValid && !stall) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_pop actual pc=%0h required=no delivery", if2dec.pc);
          end else begin
            e = expQ.pop_front();
            check("pop_pc", if2dec.pc, e);
            check("pop_inst", if2dec.inst32, memWord(e));
          end
        end
        if (flush) expQ.delete();
        if (imemReq) begin
          expQ.push_back(dec2if.pc);
          memQ.push_back('{pc: dec2if.pc, due: edgeCnt + 1 + int'($urandom_range(latHi, latLo))});
        end
      end
    end
  end

  initial begin
    int idx;
    int acc;
    logic found;

    // Reset state.
    rst = 1'b0;
    imemRdy = 1'b0;
    repeat (2) step();
    check("rst_valid", if2dec.instValid, 1'b0);
    check("rst_nop", if2dec.inst32, INST_NOP);
    check("rst_req", imemReq, 1'b0);
    check("rst_busy_rdy0", fetchBusy, 1'b1);
    imemRdy = 1'b1;
    #1;
    check("rst_busy_rdy1", fetchBusy, 1'b0);
    step();

    // Latency and back-to-back throughput with k=1.
    rst = 1'b1;
    latLo = 0; latHi = 0;
    dec2if.pc = 30'd0;
    dec2if.pcValid = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk);
      #1;
      if (n < 3) dec2if.pc = 30'(n + 1);
      else       dec2if.pcValid = 1'b0;
      @(negedge clk);
`ifdef AKARIN_FETCH_BYPASS_EN
      idx = n;
`else
      idx = n - 1;
`endif
      if (idx >= 0 && idx <= 3) begin
        check("lat_valid", if2dec.instValid, 1'b1);
        check("lat_pc", if2dec.pc, 64'(idx));
      end else begin
        check("lat_bubble", if2dec.instValid, 1'b0);
      end
    end
    step();
    idle(6);

    // Ready toggling: busy follows !ready, requests only on ready cycles.
    for (int i = 0; i < 4; i++) begin
      imemRdy = (i % 2 == 0);
      dec2if.pcValid = 1'b1;
      dec2if.pc = 30'(32'h200 + i);
      @(negedge clk);
      check("tog_busy", fetchBusy, (i % 2 != 0));
      check("tog_req", imemReq, (i % 2 == 0));
      @(posedge clk);
      #1;
    end
    idle(10);

    // Fill to capacity under stall, then release.
    stall = 1'b1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      dec2if.pcValid = 1'b1;
      dec2if.pc = 30'(32'h100 + i);
      @(negedge clk);
      if (imemReq) acc++;
      @(posedge clk);
      #1;
    end
    check("full_accepts", acc, 4);
    @(negedge clk);
    check("full_busy", fetchBusy, 1'b1);
    check("full_req", imemReq, 1'b0);
    step();
    idle(12);
    check("full_drain", expQ.size(), 0);

    // Flush with three in flight at k=3; the first response lands in the flush cycle.
    latLo = 2; latHi = 2;
    for (int i = 0; i < 3; i++) begin
      dec2if.pcValid = 1'b1;
      dec2if.pc = 30'(32'h10 + i);
      step();
    end
    dec2if.pcValid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    dec2if.pcValid = 1'b1;
    dec2if.pc = 30'h40;
    step();
    dec2if.pcValid = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 30 && !found; t++) begin
      @(negedge clk);
      if (if2dec.instValid && if2dec.pc == 30'h40) found = 1'b1;
    end
    check("flush_then_0x40", found, 1'b1);
    latLo = 0; latHi = 0;
    step();
    idle(10);
    check("flush_drain", expQ.size(), 0);

    // Randomized traffic against the scoreboard.
    latLo = 0; latHi = 3;
    for (int c = 0; c < 800; c++) begin
      dec2if.pcValid = ($urandom % 4) != 0;
      dec2if.pc = 30'($urandom);
      stall = ($urandom % 4) == 0;
      imemRdy = ($urandom % 5) != 0;
      flush = ($urandom % 32) == 0;
      step();
    end
    idle(25);
    check("rand_drain", expQ.size(), 0);
    check("rand_mem_idle", memQ.size(), 0);

    // Async reset with a full buffer.
    latLo = 0; latHi = 0;
    stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dec2if.pcValid = 1'b1;
      dec2if.pc = 30'(32'h300 + i);
      step();
    end
    dec2if.pcValid = 1'b0;
    #1;
    check("prerst_valid", if2dec.instValid, 1'b1);
    check("prerst_busy", fetchBusy, 1'b1);
    rst = 1'b0;
    #1;
    check("arst_valid", if2dec.instValid, 1'b0);
    check("arst_req", imemReq, 1'b0);
    check("arst_nop", if2dec.inst32, INST_NOP);
    check("arst_empty", fetchBusy, 1'b0);
    step();
    step();
    rst = 1'b1;
    stall = 1'b0;
    dec2if.pcValid = 1'b1;
    dec2if.pc = 30'h7;
    step();
    idle(8);
    check("post_rst_drain", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
